// File: rtl/rf_wport_if.sv
// Register-file write-port bundle shared by the WB stage, the MDU, the debug channel and Regs.
// The master side is the requesters plus Regs; the slave side is the arbiter.
interface rf_wport_if;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    logic        mdu_valid;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        mdu_ready;

    logic        dbg_valid;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        dbg_ready;

    logic        wb_stall_req;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [1:0]  grant_src;

    modport master (
        output wb_we, wb_addr, wb_data,
        output mdu_valid, mdu_addr, mdu_data,
        output dbg_valid, dbg_addr, dbg_data,
        input  mdu_ready, dbg_ready, wb_stall_req,
        input  rf_we, rf_addr, rf_data, grant_src
    );

    modport slave (
        input  wb_we, wb_addr, wb_data,
        input  mdu_valid, mdu_addr, mdu_data,
        input  dbg_valid, dbg_addr, dbg_data,
        output mdu_ready, dbg_ready, wb_stall_req,
        output rf_we, rf_addr, rf_data, grant_src
    );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Fixed-priority (WB > MDU > DBG) arbiter for the single register-file write port, with
// starvation counters that force a one-cycle WB stall so a waiting MDU/DBG write always lands.
module rf_wport_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic      clk,
    input  logic      rst,
    rf_wport_if.slave bus
);

    typedef enum logic [1:0] {
        NORM      = 2'd0,
        FORCE_MDU = 2'd1,
        FORCE_DBG = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] mdu_wait_q, mdu_wait_d;
    logic [CNT_W-1:0] dbg_wait_q, dbg_wait_d;
    logic             wb_req;
    logic             grant_wb, grant_mdu, grant_dbg;

    function automatic logic [CNT_W-1:0] wait_next(input logic             pending,
                                                   input logic [CNT_W-1:0] cur);
        if (!pending)          return '0;
        else if (cur == LIMIT) return cur;
        else                   return cur + CNT_W'(1);
    endfunction

    // A WB write to x0 leaves the port free for MDU/DBG.
    assign wb_req = bus.wb_we && (bus.wb_addr != 5'd0);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        grant_wb  = 1'b0;
        grant_mdu = 1'b0;
        grant_dbg = 1'b0;
        if (!rst) begin
            case (state_q)
                NORM: begin
                    if (wb_req)             grant_wb  = 1'b1;
                    else if (bus.mdu_valid) grant_mdu = 1'b1;
                    else if (bus.dbg_valid) grant_dbg = 1'b1;
                end
                FORCE_MDU: grant_mdu = bus.mdu_valid;
                FORCE_DBG: grant_dbg = bus.dbg_valid;
                default: ;
            endcase
        end
    end

    // The force decision looks at the post-update counter so the stall lands on the
    // cycle right after the limit is reached.
    always_comb begin
        mdu_wait_d = wait_next(bus.mdu_valid && !grant_mdu, mdu_wait_q);
        dbg_wait_d = wait_next(bus.dbg_valid && !grant_dbg, dbg_wait_q);
        state_d    = NORM;
        case (state_q)
            NORM: begin
                if (mdu_wait_d == LIMIT)      state_d = FORCE_MDU;
                else if (dbg_wait_d == LIMIT) state_d = FORCE_DBG;
            end
            FORCE_MDU: begin
                if (dbg_wait_d == LIMIT) state_d = FORCE_DBG;
            end
            default: state_d = NORM;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= NORM;
            mdu_wait_q <= '0;
            dbg_wait_q <= '0;
        end else begin
            state_q    <= state_d;
            mdu_wait_q <= mdu_wait_d;
            dbg_wait_q <= dbg_wait_d;
        end
    end

    always_comb begin
        bus.rf_we     = 1'b0;
        bus.rf_addr   = 5'd0;
        bus.rf_data   = 32'd0;
        bus.grant_src = 2'd0;
        if (grant_wb) begin
            bus.rf_we     = 1'b1;
            bus.rf_addr   = bus.wb_addr;
            bus.rf_data   = bus.wb_data;
            bus.grant_src = 2'd1;
        end else if (grant_mdu) begin
            bus.rf_we     = (bus.mdu_addr != 5'd0);
            bus.rf_addr   = bus.mdu_addr;
            bus.rf_data   = bus.mdu_data;
            bus.grant_src = 2'd2;
        end else if (grant_dbg) begin
            bus.rf_we     = (bus.dbg_addr != 5'd0);
            bus.rf_addr   = bus.dbg_addr;
            bus.rf_data   = bus.dbg_data;
            bus.grant_src = 2'd3;
        end
    end

    assign bus.mdu_ready    = grant_mdu;
    assign bus.dbg_ready    = grant_dbg;
    assign bus.wb_stall_req = !rst && (state_q != NORM);

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Scoreboard bench for rf_wport_arbiter: directed scenarios plus randomized traffic,
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_rf_wport_arbiter;

    localparam int LIMIT = 4;

    typedef struct packed {
        logic        stall;
        logic        mdu_rdy;
        logic        dbg_rdy;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [1:0]  src;
    } obs_t;

    logic clk = 1'b0;
    logic rst;

    rf_wport_if bus ();

    rf_wport_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    obs_t exp_q[$];
    obs_t last_exp;
    obs_t smp;

    // Model state: which requester owns the next cycle (0 none, 2 MDU, 3 DBG) and how many
    // consecutive cycles each requester has been refused.
    int m_force;
    int m_mw;
    int m_dw;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.stall   = bus.wb_stall_req;
        o.mdu_rdy = bus.mdu_ready;
        o.dbg_rdy = bus.dbg_ready;
        o.we      = bus.rf_we;
        o.addr    = bus.rf_addr;
        o.data    = bus.rf_data;
        o.src     = bus.grant_src;
        return o;
    endfunction

    task automatic model_reset();
        m_force = 0;
        m_mw    = 0;
        m_dw    = 0;
    endtask

    task automatic model_cycle(output obs_t e);
        int win;
        e = '0;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_force == 0)
            win = (bus.wb_we && bus.wb_addr != 0) ? 1 : bus.mdu_valid ? 2 : bus.dbg_valid ? 3 : 0;
        else if (m_force == 2)
            win = bus.mdu_valid ? 2 : 0;
        else
            win = bus.dbg_valid ? 3 : 0;
        e.stall   = (m_force != 0);
        e.src     = 2'(win);
        e.mdu_rdy = (win == 2);
        e.dbg_rdy = (win == 3);
        if (win == 1) begin
            e.we = 1'b1; e.addr = bus.wb_addr; e.data = bus.wb_data;
        end else if (win == 2) begin
            e.we = (bus.mdu_addr != 0); e.addr = bus.mdu_addr; e.data = bus.mdu_data;
        end else if (win == 3) begin
            e.we = (bus.dbg_addr != 0); e.addr = bus.dbg_addr; e.data = bus.dbg_data;
        end
        m_mw = (bus.mdu_valid && win != 2) ? ((m_mw < LIMIT) ? m_mw + 1 : LIMIT) : 0;
        m_dw = (bus.dbg_valid && win != 3) ? ((m_dw < LIMIT) ? m_dw + 1 : LIMIT) : 0;
        if (m_force == 0)      m_force = (m_mw == LIMIT) ? 2 : (m_dw == LIMIT) ? 3 : 0;
        else if (m_force == 2) m_force = (m_dw == LIMIT) ? 3 : 0;
        else                   m_force = 0;
    endtask

    // Inputs for the cycle are already driven; predict, sample mid-cycle, then cross the edge.
    task automatic tick();
        model_cycle(last_exp);
        exp_q.push_back(last_exp);
        #2 smp = observe();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.wb_we     = 1'b0; bus.wb_addr  = 5'd0; bus.wb_data  = 32'd0;
        bus.mdu_valid = 1'b0; bus.mdu_addr = 5'd0; bus.mdu_data = 32'd0;
        bus.dbg_valid = 1'b0; bus.dbg_addr = 5'd0; bus.dbg_data = 32'd0;
    endtask

    initial begin : monitor
        int   n;
        obs_t e;
        n = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("sb_cycle%0d", n), 64'(observe()), 64'(e));
                n++;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

    initial begin : stim
        int stalls;
        rst = 1'b1;
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;

        // Reset held with every requester active.
        bus.wb_we = 1'b1;     bus.wb_addr  = 5'd9; bus.wb_data  = 32'h1111_0009;
        bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd4; bus.mdu_data = 32'h2222_0004;
        bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd2; bus.dbg_data = 32'h3333_0002;
        tick();
        check("rst_outputs", 64'(smp), 64'd0);
        tick();
        rst = 1'b0;
        bus.wb_we = 1'b0;
        tick();
        check("rel_mdu_src",  64'(smp.src),     64'd2);
        check("rel_mdu_rdy",  64'(smp.mdu_rdy), 64'd1);
        check("rel_mdu_we",   64'(smp.we),      64'd1);
        check("rel_mdu_addr", 64'(smp.addr),    64'd4);
        bus.mdu_valid = 1'b0;
        tick();
        check("rel_dbg_src", 64'(smp.src), 64'd3);
        bus.dbg_valid = 1'b0;
        tick();

        // Priority: WB beats MDU, MDU goes next.
        bus.wb_we = 1'b1;     bus.wb_addr  = 5'd5; bus.wb_data  = 32'hA5A5_0005;
        bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd6; bus.mdu_data = 32'h6666_0006;
        tick();
        check("prio_addr",    64'(smp.addr),    64'd5);
        check("prio_src",     64'(smp.src),     64'd1);
        check("prio_mdu_rdy", 64'(smp.mdu_rdy), 64'd0);
        bus.wb_we = 1'b0;
        tick();
        check("prio_next_addr", 64'(smp.addr),    64'd6);
        check("prio_next_rdy",  64'(smp.mdu_rdy), 64'd1);
        check("prio_next_data", 64'(smp.data),    64'h6666_0006);
        bus.mdu_valid = 1'b0;
        tick();

        // Single starvation: stall lands exactly on cycle 5.
        bus.wb_we = 1'b1;     bus.wb_addr  = 5'd7; bus.wb_data  = 32'h7777_0007;
        bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd8; bus.mdu_data = 32'h8888_0008;
        for (int c = 1; c <= 6; c++) begin
            tick();
            check($sformatf("starve_stall_c%0d", c), 64'(smp.stall), 64'(c == 5));
            if (c == 5) begin
                check("starve_mdu_grant", 64'(smp.src), 64'd2);
                bus.mdu_valid = 1'b0;
            end
            if (c == 6) check("starve_wb_resume", 64'(smp.src), 64'd1);
        end
        bus.wb_we = 1'b0;
        tick();

        // Dual starvation: MDU then DBG on consecutive cycles.
        stalls = 0;
        bus.wb_we = 1'b1;
        bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd10; bus.mdu_data = 32'h0A0A_000A;
        bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd11; bus.dbg_data = 32'h0B0B_000B;
        for (int c = 1; c <= 7; c++) begin
            tick();
            stalls += int'(smp.stall);
            if (c == 5) begin
                check("dual_c5_src", 64'(smp.src), 64'd2);
                bus.mdu_valid = 1'b0;
            end
            if (c == 6) begin
                check("dual_c6_src", 64'(smp.src), 64'd3);
                bus.dbg_valid = 1'b0;
            end
            if (c == 7) check("dual_c7_src", 64'(smp.src), 64'd1);
        end
        check("dual_stall_count", 64'(stalls), 64'd2);
        bus.wb_we = 1'b0;
        tick();

        // x0 handling.
        bus.dbg_valid = 1'b1; bus.dbg_addr = 5'd0; bus.dbg_data = 32'hDEAD_BEEF;
        tick();
        check("x0_dbg_rdy", 64'(smp.dbg_rdy), 64'd1);
        check("x0_dbg_we",  64'(smp.we),      64'd0);
        check("x0_dbg_src", 64'(smp.src),     64'd3);
        bus.dbg_valid = 1'b0;
        bus.wb_we = 1'b1;     bus.wb_addr  = 5'd0; bus.wb_data  = 32'h0000_1234;
        bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd3; bus.mdu_data = 32'h3333_0003;
        tick();
        check("x0_wb_mdu_src",  64'(smp.src),  64'd2);
        check("x0_wb_mdu_we",   64'(smp.we),   64'd1);
        check("x0_wb_mdu_addr", 64'(smp.addr), 64'd3);
        bus.mdu_valid = 1'b0;
        bus.wb_we = 1'b0;
        tick();

        // Async reset pulse between edges with mdu_wait at 3.
        bus.wb_we = 1'b1;     bus.wb_addr  = 5'd7;  bus.wb_data  = 32'h7777_1007;
        bus.mdu_valid = 1'b1; bus.mdu_addr = 5'd12; bus.mdu_data = 32'hC0C0_000C;
        repeat (3) tick();
        rst = 1'b1;
        #2;
        check("pulse_outputs", 64'(observe()), 64'd0);
        model_reset();
        rst = 1'b0;
        #1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check($sformatf("pulse_stall_c%0d", c), 64'(smp.stall), 64'(c == 5));
            if (c == 5) bus.mdu_valid = 1'b0;
        end
        bus.wb_we = 1'b0;
        tick();

        // Randomized traffic with occasional async resets; requesters hold until accepted.
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(99) == 0);
            bus.wb_we   = ($urandom_range(9) < 6);
            bus.wb_addr = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
            bus.wb_data = $urandom;
            if (!bus.mdu_valid && $urandom_range(2) == 0) begin
                bus.mdu_valid = 1'b1;
                bus.mdu_addr  = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
                bus.mdu_data  = $urandom;
            end
            if (!bus.dbg_valid && $urandom_range(3) == 0) begin
                bus.dbg_valid = 1'b1;
                bus.dbg_addr  = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
                bus.dbg_data  = $urandom;
            end
            tick();
            if (last_exp.mdu_rdy) bus.mdu_valid = 1'b0;
            if (last_exp.dbg_rdy) bus.dbg_valid = 1'b0;
        end

        rst = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
